comp_video_enc: RTL and testbench

Parametrised 4fsc composite video encoder. It is the successor to the team's fixed-width NTSC colour encoder. It takes 4:4:4 Y/U/V samples plus BURST/BLANK/SYNC timing flags from the timing generator and produces a saturated unsigned composite sample for the video DAC. It adds NTSC/PAL mode with per-line V-switch, configurable levels and widths, and a three-stage clock-enabled pipeline.

---
 rtl/comp_video_pkg.sv | 27 ++
 rtl/comp_video_enc_if.sv | 30 +++
 rtl/comp_video_carrier.sv | 48 ++++
 rtl/comp_video_enc.sv | 119 +++++++++++
 tb/tb_comp_video_enc.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/comp_video_pkg.sv
// Shared constants and helpers for the composite video encoder.
// Default levels are in output codes for the 10-bit default output width.
package comp_video_pkg;

    localparam int unsigned DEF_SYNC_LVL  = 16;
    localparam int unsigned DEF_BLANK_LVL = 240;
    localparam int unsigned DEF_SETUP     = 42;
    localparam int unsigned DEF_BURST_AMP = 64;

    localparam int unsigned PH_W = 2;

    localparam logic [PH_W-1:0] PH_U  = 2'd0;
    localparam logic [PH_W-1:0] PH_V  = 2'd1;
    localparam logic [PH_W-1:0] PH_NU = 2'd2;
    localparam logic [PH_W-1:0] PH_NV = 2'd3;

    // Clamp a signed value into the unsigned range [0, 2^ow-1].
    function automatic logic [31:0] saturate(input logic signed [31:0] x,
                                             input int unsigned ow);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< ow) - 32'sd1;
        if (x < 32'sd0) return 32'd0;
        if (x > hi)     return $unsigned(hi);
        return $unsigned(x);
    endfunction

endpackage

// File: rtl/comp_video_enc_if.sv
// Sample/flag bus between the timing generator (master) and the encoder (slave).
interface comp_video_enc_if #(
    parameter int unsigned YW = 8,
    parameter int unsigned CW = 8,
    parameter int unsigned OW = 10
);
    logic                 CK_EE_i;
    logic                 MODE_PAL_i;
    logic                 LINE_i;
    logic [YW-1:0]        YYs_i;
    logic signed [CW-1:0] UUs_i;
    logic signed [CW-1:0] VVs_i;
    logic                 BURST_i;
    logic                 BLANK_i;
    logic                 SYNC_i;
    logic [OW-1:0]        VIDEOs_o;
    logic                 VSW_o;

    modport master (
        output CK_EE_i, MODE_PAL_i, LINE_i, YYs_i, UUs_i, VVs_i,
        output BURST_i, BLANK_i, SYNC_i,
        input  VIDEOs_o, VSW_o
    );

    modport slave (
        input  CK_EE_i, MODE_PAL_i, LINE_i, YYs_i, UUs_i, VVs_i,
        input  BURST_i, BLANK_i, SYNC_i,
        output VIDEOs_o, VSW_o
    );
endinterface

// File: rtl/comp_video_carrier.sv
// Subcarrier phase counter and PAL V-switch; supplies stage-1 phase and V sign.
module comp_video_carrier
    import comp_video_pkg::*;
(
    input  logic            CK_i,
    input  logic            XR_i,
    input  logic            en_i,
    input  logic            mode_pal_i,
    input  logic            line_i,
    output logic [PH_W-1:0] ph_o,
    output logic            s_neg_o,
    output logic            vsw_o
);

    logic [PH_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            vsw_q, vsw_d;

    // cnt_q holds the phase of the next sample so the first enabled cycle registers 0
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        vsw_d = vsw_q;
        if (en_i) begin
            ph_d  = cnt_q;
            cnt_d = cnt_q + 2'd1;
            vsw_d = mode_pal_i ? (vsw_q ^ line_i) : 1'b0;
        end
    end

    always_ff @(posedge CK_i) begin
        if (!XR_i) begin
            cnt_q <= '0;
            ph_q  <= '0;
            vsw_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
            vsw_q <= vsw_d;
        end
    end

    assign ph_o    = ph_q;
    // VSW is forced low in NTSC, so it alone selects the V sign
    assign s_neg_o = vsw_q;
    assign vsw_o   = vsw_q;

endmodule

// File: rtl/comp_video_enc.sv
// 4fsc NTSC/PAL composite encoder: input register, level/carrier sum, saturating output.
// Every register advances only on CK_EE_i; XR_i clears the whole pipe synchronously.
module comp_video_enc
    import comp_video_pkg::*;
#(
    parameter int unsigned YW        = 8,
    parameter int unsigned CW        = 8,
    parameter int unsigned OW        = 10,
    parameter int unsigned SYNC_LVL  = DEF_SYNC_LVL,
    parameter int unsigned BLANK_LVL = DEF_BLANK_LVL,
    parameter int unsigned SETUP     = DEF_SETUP,
    parameter int unsigned BURST_AMP = DEF_BURST_AMP
) (
    input  logic            CK_i,
    input  logic            XR_i,
    comp_video_enc_if.slave bus
);

    localparam int unsigned SW = OW + 2;
    localparam logic signed [CW-1:0] C_MIN   = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [CW-1:0] C_CLAMP = {1'b1, {(CW-2){1'b0}}, 1'b1};

    logic [YW-1:0]        y_q, y_d;
    logic signed [CW-1:0] u_q, u_d, v_q, v_d;
    logic                 burst_q, burst_d, blank_q, blank_d;
    logic                 sync_q, sync_d, mode_q, mode_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic [OW-1:0]        video_q, video_d;

    logic [PH_W-1:0]      ph;
    logic                 s_neg;
    logic                 vsw;

    logic signed [SW-1:0] ys_c, us_c, vs_c, cu_c, cv_c, car_c, sum_c;

    comp_video_carrier u_carrier (
        .CK_i       (CK_i),
        .XR_i       (XR_i),
        .en_i       (bus.CK_EE_i),
        .mode_pal_i (bus.MODE_PAL_i),
        .line_i     (bus.LINE_i),
        .ph_o       (ph),
        .s_neg_o    (s_neg),
        .vsw_o      (vsw)
    );

    // Stage 2: scale terms, pick carrier component by phase, apply level priority
    always_comb begin
        ys_c  = SW'($signed({1'b0, y_q})) <<< (OW - YW - 1);
        us_c  = SW'(u_q) <<< (OW - CW - 1);
        vs_c  = SW'(v_q) <<< (OW - CW - 1);
        cu_c  = burst_q ? -$signed(SW'(BURST_AMP)) : us_c;
        cv_c  = burst_q ? (mode_q ? $signed(SW'(BURST_AMP)) : '0) : vs_c;
        car_c = '0;
        if (s_neg) cv_c = -cv_c;
        case (ph)
            PH_U:    car_c = cu_c;
            PH_V:    car_c = cv_c;
            PH_NU:   car_c = -cu_c;
            default: car_c = -cv_c;
        endcase
        if (!sync_q)      sum_c = $signed(SW'(SYNC_LVL));
        else if (burst_q) sum_c = $signed(SW'(BLANK_LVL)) + car_c;
        else if (blank_q) sum_c = $signed(SW'(BLANK_LVL));
        else              sum_c = $signed(SW'(BLANK_LVL + SETUP)) + ys_c + car_c;
    end

    // Next state for stage 1 (with symmetric chroma clamp), stage 2 and stage 3
    always_comb begin
        y_d     = y_q;
        u_d     = u_q;
        v_d     = v_q;
        burst_d = burst_q;
        blank_d = blank_q;
        sync_d  = sync_q;
        mode_d  = mode_q;
        sum_d   = sum_q;
        video_d = video_q;
        if (bus.CK_EE_i) begin
            y_d     = bus.YYs_i;
            u_d     = (bus.UUs_i == C_MIN) ? C_CLAMP : bus.UUs_i;
            v_d     = (bus.VVs_i == C_MIN) ? C_CLAMP : bus.VVs_i;
            burst_d = bus.BURST_i;
            blank_d = bus.BLANK_i;
            sync_d  = bus.SYNC_i;
            mode_d  = bus.MODE_PAL_i;
            sum_d   = sum_c;
            video_d = OW'(saturate(32'(sum_q), OW));
        end
    end

    always_ff @(posedge CK_i) begin
        if (!XR_i) begin
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            burst_q <= 1'b0;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
            mode_q  <= 1'b0;
            sum_q   <= '0;
            video_q <= '0;
        end else begin
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
            burst_q <= burst_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
            video_q <= video_d;
        end
    end

    assign bus.VIDEOs_o = video_q;
    assign bus.VSW_o    = vsw;

endmodule

// File: tb/tb_comp_video_enc.sv
// Bench for comp_video_enc: phase-ordered vector table, hand sequences for the
// V-switch/reset corners, and random traffic against an arithmetic reference.
module tb_comp_video_enc;

    localparam int YW = 8;
    localparam int CW = 8;
    localparam int OW = 10;
    localparam int SYNC_LVL  = 16;
    localparam int BLANK_LVL = 240;
    localparam int SETUP     = 42;
    localparam int BURST_AMP = 64;

    logic CK_i = 1'b0;
    logic XR_i = 1'b0;

    comp_video_enc_if #(.YW(YW), .CW(CW), .OW(OW)) bus ();

    comp_video_enc dut (
        .CK_i (CK_i),
        .XR_i (XR_i),
        .bus  (bus)
    );

    always #5 CK_i = ~CK_i;

    int checks = 0;
    int errors = 0;

    // reference state: next phase, V-switch, samples in flight (oldest first)
    int ph_m  = 0;
    bit vsw_m = 1'b0;
    int dly[$];
    int exp_out = 0;

    typedef struct {
        string name;
        int    y, u, v;
        bit    burst, blank, sync, mode, line1, toggle;
        int    exp [4];
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Composite value of one sample computed from the level/carrier rules
    function automatic int ref_sample(input int y, input int u, input int v,
                                      input bit burst, input bit blank, input bit sync,
                                      input bit mode, input bit sneg, input int ph);
        int cu, cv, sg, car, lvl;
        if (u == -(1 << (CW-1))) u = -(1 << (CW-1)) + 1;
        if (v == -(1 << (CW-1))) v = -(1 << (CW-1)) + 1;
        if (burst) begin
            cu = -BURST_AMP;
            cv = mode ? BURST_AMP : 0;
        end else begin
            cu = u * (1 << (OW-CW-1));
            cv = v * (1 << (OW-CW-1));
        end
        sg  = (ph >= 2) ? -1 : 1;
        car = (ph % 2 == 0) ? sg * cu : sg * (sneg ? -1 : 1) * cv;
        if (!sync)      lvl = SYNC_LVL;
        else if (burst) lvl = BLANK_LVL + car;
        else if (blank) lvl = BLANK_LVL;
        else            lvl = BLANK_LVL + SETUP + y * (1 << (OW-YW-1)) + car;
        if (lvl < 0) return 0;
        if (lvl > (1 << OW) - 1) return (1 << OW) - 1;
        return lvl;
    endfunction

    // One clock: advance the reference on the edge, compare outputs 1 time unit later
    task automatic tick();
        int s;
        @(posedge CK_i);
        if (!XR_i) begin
            ph_m  = 0;
            vsw_m = 1'b0;
            dly.delete();
            dly.push_back(0);
            dly.push_back(SYNC_LVL);
            exp_out = 0;
        end else if (bus.CK_EE_i) begin
            vsw_m = bus.MODE_PAL_i ? (vsw_m ^ bus.LINE_i) : 1'b0;
            s = ref_sample(int'(bus.YYs_i), int'($signed(bus.UUs_i)), int'($signed(bus.VVs_i)),
                           bus.BURST_i, bus.BLANK_i, bus.SYNC_i, bus.MODE_PAL_i, vsw_m, ph_m);
            ph_m = (ph_m + 1) % 4;
            dly.push_back(s);
            exp_out = dly.pop_front();
        end
        #1;
        chk("model_video", int'(bus.VIDEOs_o), exp_out);
        chk("model_vsw", int'(bus.VSW_o), int'(vsw_m));
    endtask

    task automatic drive(input int y, input int u, input int v, input bit burst,
                         input bit blank, input bit sync, input bit mode);
        bus.YYs_i      = YW'(y);
        bus.UUs_i      = CW'(u);
        bus.VVs_i      = CW'(v);
        bus.BURST_i    = burst;
        bus.BLANK_i    = blank;
        bus.SYNC_i     = sync;
        bus.MODE_PAL_i = mode;
    endtask

    task automatic do_reset(input int n);
        XR_i = 1'b0;
        bus.LINE_i = 1'b0;
        bus.CK_EE_i = 1'b1;
        repeat (n) tick();
        XR_i = 1'b1;
    endtask

    function automatic vec_t mk(input string name, input int y, input int u, input int v,
                                input bit burst, input bit blank, input bit sync,
                                input bit mode, input bit line1, input bit toggle,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t r;
        r.name = name; r.y = y; r.u = u; r.v = v;
        r.burst = burst; r.blank = blank; r.sync = sync; r.mode = mode;
        r.line1 = line1; r.toggle = toggle;
        r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3;
        return r;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 1, 0);
        bus.LINE_i  = 1'b0;
        bus.CK_EE_i = 1'b1;

        //           name        Y    U     V   bu bl sy pal ln tg   PH0   PH1   PH2   PH3
        tbl.push_back(mk("luma_ntsc",  100,   0,  0, 0, 0, 1, 0, 0, 0,  482,  482,  482,  482));
        tbl.push_back(mk("chroma_ntsc",128,  40,  0, 0, 0, 1, 0, 0, 0,  618,  538,  458,  538));
        tbl.push_back(mk("chroma_ee",  128,  40,  0, 0, 0, 1, 0, 0, 1,  618,  538,  458,  538));
        tbl.push_back(mk("burst_ntsc",  77,  33, 91, 1, 1, 1, 0, 0, 0,  176,  240,  304,  240));
        tbl.push_back(mk("sync_tip",   200,  50, 20, 1, 0, 0, 1, 0, 0,   16,   16,   16,   16));
        tbl.push_back(mk("pal_v",        0,   0, 40, 0, 0, 1, 1, 0, 0,  282,  362,  282,  202));
        tbl.push_back(mk("pal_v_line",   0,   0, 40, 0, 0, 1, 1, 1, 0,  282,  202,  282,  362));
        tbl.push_back(mk("pal_burst",    9,  11, 13, 1, 1, 1, 1, 0, 0,  176,  304,  304,  176));
        tbl.push_back(mk("sat_high",   255, 127,  0, 0, 0, 1, 0, 0, 0, 1023,  792,  538,  792));
        tbl.push_back(mk("sat_negmin",   0,-128,  0, 0, 0, 1, 0, 0, 0,   28,  282,  536,  282));
        tbl.push_back(mk("sat_pos_ph2",  0, 127,  0, 0, 0, 1, 0, 0, 0,  536,  282,   28,  282));

        // random traffic, with rare resets and mode changes
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            XR_i           = ($urandom_range(0, 199) != 0);
            bus.CK_EE_i    = ($urandom_range(0, 3) != 0);
            bus.LINE_i     = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 79) == 0) bus.MODE_PAL_i = ~bus.MODE_PAL_i;
            bus.YYs_i      = YW'($urandom);
            bus.UUs_i      = CW'($urandom);
            bus.VVs_i      = CW'($urandom);
            bus.BURST_i    = ($urandom_range(0, 5) == 0);
            bus.BLANK_i    = ($urandom_range(0, 5) == 0);
            bus.SYNC_i     = ($urandom_range(0, 9) != 0);
            tick();
        end

        // reset mid-operation with V-switch set and random inputs
        XR_i = 1'b1;
        drive(50, 60, 70, 0, 0, 1, 1);
        bus.CK_EE_i = 1'b1;
        bus.LINE_i  = 1'b1;
        tick();
        bus.LINE_i  = 1'b0;
        tick();
        XR_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.CK_EE_i = 1'($urandom);
            bus.LINE_i  = 1'($urandom);
            drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
            tick();
            chk("reset_video", int'(bus.VIDEOs_o), 0);
            chk("reset_vsw", int'(bus.VSW_o), 0);
        end

        // phase-ordered vectors, each started from reset so PH0 lands on the 3rd enabled edge
        foreach (tbl[i]) begin
            do_reset(2);
            drive(tbl[i].y, tbl[i].u, tbl[i].v, tbl[i].burst, tbl[i].blank,
                  tbl[i].sync, tbl[i].mode);
            for (int k = 1; k <= 6; k++) begin
                bus.LINE_i  = tbl[i].line1 && (k == 1);
                bus.CK_EE_i = 1'b1;
                tick();
                if (k >= 3) chk($sformatf("%s_ph%0d", tbl[i].name, k-3),
                                int'(bus.VIDEOs_o), tbl[i].exp[k-3]);
                if (tbl[i].toggle) begin
                    bus.LINE_i  = 1'b0;
                    bus.CK_EE_i = 1'b0;
                    tick();
                    if (k >= 3) chk($sformatf("%s_hold%0d", tbl[i].name, k-3),
                                    int'(bus.VIDEOs_o), tbl[i].exp[k-3]);
                end
            end
        end

        // V-switch corners: disabled LINE, switch to NTSC, LINE during reset
        do_reset(2);
        drive(0, 0, 40, 0, 0, 1, 1);
        bus.LINE_i = 1'b1;
        tick();
        chk("vsw_after_line", int'(bus.VSW_o), 1);
        bus.CK_EE_i = 1'b0;
        tick();
        chk("vsw_line_disabled", int'(bus.VSW_o), 1);
        bus.LINE_i  = 1'b0;
        bus.CK_EE_i = 1'b1;
        tick();
        bus.MODE_PAL_i = 1'b0;
        tick();
        chk("vsw_to_ntsc", int'(bus.VSW_o), 0);
        bus.MODE_PAL_i = 1'b1;
        bus.LINE_i = 1'b1;
        XR_i = 1'b0;
        tick();
        chk("vsw_line_in_reset", int'(bus.VSW_o), 0);
        XR_i = 1'b1;
        bus.LINE_i = 1'b0;
        tick();
        chk("vsw_after_reset", int'(bus.VSW_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
